logic_sync_filter: RTL

// - Parametrised successor to the single-array CDC synchroniser. It brings a quasi-static

---
 rtl/logic_sync_filter.sv | 105 ++++++++++
 1 files changed

// File: rtl/logic_sync_filter.sv
// logic_sync_filter: per-bit CDC synchroniser, whole-vector stability filter and a one-entry
// change-event channel with sticky overflow. Define LOGIC_SYNC_EDGE_EN for m_rise/m_fall pulses.
module logic_sync_filter #(
    parameter int DATA_BITS     = 32,
    parameter int SYNC_STAGES   = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [DATA_BITS-1:0] s_data,
    output logic [DATA_BITS-1:0] m_level,
    output logic                 m_evt_valid,
    input  logic                 m_evt_ready,
    output logic [DATA_BITS-1:0] m_evt_data,
    output logic                 m_ovf,
`ifdef LOGIC_SYNC_EDGE_EN
    output logic [DATA_BITS-1:0] m_rise,
    output logic [DATA_BITS-1:0] m_fall,
`endif
    input  logic                 ovf_clr
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][DATA_BITS-1:0] sync;
    logic [DATA_BITS-1:0]                  samp;
    logic [DATA_BITS-1:0]                  cand;
    logic [CNT_W-1:0]                      cnt;
    logic                                  accept;
    logic                                  drop;

    assign samp = sync[SYNC_STAGES-1];

    // Once cand matches m_level the saturated counter can no longer re-accept the same value.
    assign accept = (samp == cand) && (cnt == CNT_MAX) && (cand != m_level);
    assign drop   = accept && m_evt_valid && !m_evt_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], s_data};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cand <= '0;
            cnt  <= '0;
        end else if (samp != cand) begin
            cand <= samp;
            cnt  <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_level <= '0;
        end else if (accept) begin
            m_level <= cand;
        end
    end

    // A handshake in the accept cycle frees the slot, so the new event loads without overflow.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_evt_valid <= 1'b0;
            m_evt_data  <= '0;
        end else if (accept && !drop) begin
            m_evt_valid <= 1'b1;
            m_evt_data  <= cand;
        end else if (m_evt_valid && m_evt_ready) begin
            m_evt_valid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_ovf <= 1'b0;
        end else if (drop) begin
            m_ovf <= 1'b1;
        end else if (ovf_clr) begin
            m_ovf <= 1'b0;
        end
    end

`ifdef LOGIC_SYNC_EDGE_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_rise <= '0;
            m_fall <= '0;
        end else if (accept) begin
            m_rise <= cand & ~m_level;
            m_fall <= ~cand & m_level;
        end else begin
            m_rise <= '0;
            m_fall <= '0;
        end
    end
`endif

endmodule
